// File: rtl/mips_sequencer.sv
// Multi-cycle control sequencer for the MIPS datapath.
// Latches one instruction per newinstr/ready handshake, walks it through
// DECODE, EXECUTE, MEM and WRITEBACK, and emits single-state enable strobes
// so the register file and data memory update exactly once per instruction.
// Every output is either a register or decoded from registered state only.
module mips_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instrword,
    input  logic             newinstr,
    output logic             ready,
    output logic [31:0]      ir,
    output logic [2:0]       state,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             alu_en,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             done,
    output logic             illegal,
    output logic             missed,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        C_RTYPE = 2'd0,
        C_LW    = 2'd1,
        C_SW    = 2'd2
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    // Last MEM cycle index; the wait counter runs 0..MEM_LAT-1 inside MEM.
    localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    cls_t             cls_q;
    cls_t             dec_cls;
    logic             dec_legal;
    logic [31:0]      ir_q;
    logic [3:0]       wait_q;
    logic             mem_last;
    logic             illegal_q;
    logic             missed_q;
    logic [CNT_W-1:0] count_q;

    assign state       = state_q;
    assign ir          = ir_q;
    assign ready       = (state_q == S_IDLE);
    assign illegal     = illegal_q;
    assign missed      = missed_q;
    assign instr_count = count_q;
    assign mem_last    = (wait_q == MEM_LAST);

    // Classify the latched instruction; only meaningful while in DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_RTYPE;
        case (ir_q[31:26])
            OP_RTYPE: begin
                case (ir_q[5:0])
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: dec_cls = C_RTYPE;
                    default:                          dec_legal = 1'b0;
                endcase
            end
            OP_LW:   dec_cls = C_LW;
            OP_SW:   dec_cls = C_SW;
            default: dec_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded strobes/selects.
    always_comb begin
        state_d    = state_q;
        alu_en     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        done       = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 2'b00;

        // Selects are held from EXECUTE until the instruction returns to IDLE.
        if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) begin
            case (cls_q)
                C_RTYPE: begin
                    reg_dst = 1'b1;
                    alu_op  = 2'b10;
                end
                C_LW: begin
                    alu_src    = 1'b1;
                    mem_to_reg = 1'b1;
                end
                C_SW: begin
                    alu_src = 1'b1;
                end
                default: begin
                    reg_dst = 1'b0;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (newinstr) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_legal ? S_EXECUTE : S_IDLE;
            end
            S_EXECUTE: begin
                alu_en  = 1'b1;
                state_d = (cls_q == C_RTYPE) ? S_WRITEBACK : S_MEM;
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q == C_SW);
                if (mem_last) begin
                    // A store retires in its last memory cycle.
                    done    = (cls_q == C_SW);
                    state_d = (cls_q == C_LW) ? S_WRITEBACK : S_IDLE;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction latch, class, MEM wait counter, status flags and retire count.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q      <= '0;
            cls_q     <= C_RTYPE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            missed_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (state_q == S_IDLE && newinstr) begin
                ir_q <= instrword;
            end
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
            end
            if (state_q == S_MEM) begin
                wait_q <= wait_q + 4'd1;
            end else begin
                wait_q <= '0;
            end
            // Pulse lands in the IDLE cycle that follows a rejected DECODE.
            illegal_q <= (state_q == S_DECODE) && !dec_legal;
            if (newinstr && state_q != S_IDLE) begin
                missed_q <= 1'b1;
            end
            if (done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_sequencer.sv
// Scoreboard bench for mips_sequencer: stimulus pushes expected retire /
// illegal events computed from instruction class and timing rules; a monitor
// pops them when the DUT raises done or illegal.
module tb_mips_sequencer;

    localparam int ML = 3;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instrword = '0;
    logic          newinstr = 1'b0;
    logic          ready;
    logic [31:0]   ir;
    logic [2:0]    state;
    logic          reg_dst, alu_src, mem_to_reg;
    logic [1:0]    alu_op;
    logic          alu_en, reg_write, mem_read, mem_write;
    logic          done, illegal, missed;
    logic [CW-1:0] instr_count;

    mips_sequencer #(.MEM_LAT(ML), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .instrword(instrword), .newinstr(newinstr),
        .ready(ready), .ir(ir), .state(state), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_en(alu_en),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .done(done), .illegal(illegal), .missed(missed), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    // kind: 0 R-type, 1 lw, 2 sw, 3 illegal
    typedef struct {
        int          kind;
        logic [31:0] w;
        int          ev_edge;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   idle_edge  = 0;
    int   exp_cnt    = 0;
    bit   exp_missed = 0;
    bit   armed      = 0;
    int   tests      = 0;
    int   fails      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        if (w[31:26] == 6'd35) return 1;
        if (w[31:26] == 6'd43) return 2;
        if (w[31:26] == 6'd0 && (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) return 0;
        return 3;
    endfunction

    function automatic logic [31:0] gen(input int kind);
        logic [31:0] w;
        logic [5:0]  f[5];
        f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        w = $urandom;
        case (kind)
            0: begin w[31:26] = 6'd0; w[5:0] = f[$urandom_range(0, 4)]; end
            1: w[31:26] = 6'd35;
            2: w[31:26] = 6'd43;
            default: begin
                if ($urandom_range(0, 1) == 1) w[31:26] = 6'd0;
                while (classify(w) != 3) w[5:0] = 6'($urandom);
            end
        endcase
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] w, input bit eager, input bit hold);
        exp_t e;
        int   a;
        instrword = w;
        if (eager) begin
            newinstr = 1'b1;
            while (edges < idle_edge) begin
                exp_missed = 1;
                @(negedge clock);
            end
        end else begin
            newinstr = 1'b0;
            while (edges < idle_edge) @(negedge clock);
            newinstr = 1'b1;
        end
        a      = edges + 1;
        e.kind = classify(w);
        e.w    = w;
        e.cnt  = exp_cnt % (1 << CW);
        case (e.kind)
            0:       begin e.ev_edge = a + 2;      idle_edge = a + 3;      end
            1:       begin e.ev_edge = a + 2 + ML; idle_edge = a + 3 + ML; end
            2:       begin e.ev_edge = a + 1 + ML; idle_edge = a + 2 + ML; end
            default: begin e.ev_edge = a + 1;      idle_edge = a + 1;      end
        endcase
        if (e.kind != 3) exp_cnt++;
        q.push_back(e);
        @(negedge clock);
        if (!hold) newinstr = 1'b0;
    endtask

    task automatic do_reset(input bit with_req);
        newinstr  = with_req;
        instrword = 32'h0022_1820;
        reset     = 1'b1;
        q.delete();
        exp_cnt    = 0;
        exp_missed = 0;
        @(negedge clock);
        idle_edge = edges;
        reset     = 1'b0;
        newinstr  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (edges < idle_edge && guard < 200) begin
            guard++;
            @(negedge clock);
        end
        @(negedge clock);
        check("queue_empty", q.size(), 0);
    endtask

    // Monitor: per-cycle invariants plus scoreboard pops on done/illegal.
    initial begin
        int   n_alu = 0, n_rd = 0, n_wr = 0, n_rw = 0;
        exp_t e;
        logic [31:0] exp_str, exp_sel;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                armed = 1;
                check("rst_state", state, 0);
                check("rst_ready", ready, 1);
                check("rst_ir", ir, 0);
                check("rst_count", instr_count, 0);
                check("rst_missed", missed, 0);
                check("rst_pulses", {done, illegal}, 0);
                check("rst_strobes", {alu_en, reg_write, mem_read, mem_write}, 0);
                check("rst_selects", {reg_dst, alu_src, mem_to_reg, alu_op}, 0);
                n_alu = 0; n_rd = 0; n_wr = 0; n_rw = 0;
                continue;
            end
            if (!armed) continue;
            n_alu += int'(alu_en);
            n_rd  += int'(mem_read);
            n_wr  += int'(mem_write);
            n_rw  += int'(reg_write);
            check("rd_wr_exclusive", mem_read & mem_write, 0);
            check("rw_mem_exclusive", reg_write & (mem_read | mem_write), 0);
            check("ready", ready, edges >= idle_edge);
            check("missed", missed, exp_missed);
            if (edges >= idle_edge)
                check("idle_selects", {reg_dst, alu_src, mem_to_reg, alu_op}, 0);
            if (done || illegal) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: done=%0b illegal=%0b with empty queue (edge %0d)",
                             done, illegal, edges);
                end else begin
                    e = q.pop_front();
                    check("event_edge", edges, e.ev_edge);
                    check("illegal_pulse", illegal, e.kind == 3);
                    check("done_pulse", done, e.kind != 3);
                    check("ir", ir, e.w);
                    check("count_at_event", instr_count, e.cnt);
                    case (e.kind)
                        0:       begin exp_str = {8'd1, 8'd0, 8'd0, 8'd1};         exp_sel = 32'b10010; end
                        1:       begin exp_str = {8'd1, 8'(ML), 8'd0, 8'd1};       exp_sel = 32'b01100; end
                        2:       begin exp_str = {8'd1, 8'd0, 8'(ML), 8'd0};       exp_sel = 32'b01000; end
                        default: begin exp_str = 32'd0;                             exp_sel = 32'd0;     end
                    endcase
                    check("strobe_counts", {8'(n_alu), 8'(n_rd), 8'(n_wr), 8'(n_rw)}, exp_str);
                    check("selects", {reg_dst, alu_src, mem_to_reg, alu_op}, exp_sel);
                    if (e.kind == 3) check("illegal_state", state, 0);
                end
                n_alu = 0; n_rd = 0; n_wr = 0; n_rw = 0;
            end
        end
    end

    // Stimulus.
    initial begin
        int k;
        @(negedge clock);
        do_reset(0);
        do_reset(0);

        // Directed: add, lw, sw, two illegals.
        issue(32'h0022_1820, 0, 0);
        issue(32'h8C22_0004, 0, 0);
        issue(32'hAC22_0008, 0, 0);
        issue(32'h1022_0001, 0, 0);
        issue(32'h0022_1827, 0, 0);
        drain();

        // newinstr during EXECUTE of an add is ignored and flags missed.
        issue(32'h0022_1820, 0, 0);
        @(negedge clock);
        instrword  = 32'hDEAD_BEEF;
        newinstr   = 1'b1;
        exp_missed = 1;
        @(negedge clock);
        newinstr = 1'b0;
        drain();

        // Reset in the middle of a lw's MEM phase aborts it.
        issue(32'h8C22_0004, 0, 0);
        repeat (3) @(negedge clock);
        check("pre_reset_mem", state, 3);
        do_reset(0);

        // Back-to-back R-types with newinstr held high; count wraps.
        for (int i = 0; i < 17; i++)
            issue(gen(0), 1, i != 16);
        drain();
        check("wrap_count", instr_count, 1);

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            issue(gen(k < 4 ? 0 : k < 6 ? 1 : k < 8 ? 2 : 3), $urandom_range(0, 3) == 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        drain();
        check("final_count", instr_count, 32'(exp_cnt % (1 << CW)));

        // Reset coincident with a request: nothing latched, then normal operation.
        do_reset(1);
        @(negedge clock);
        check("post_reset_idle", state, 0);
        issue(32'h0022_182A, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edges);
        $fatal(1, "watchdog");
    end

endmodule
